// File: rtl/weight_tile_buffer_if.sv
// weight_tile_buffer_if: bundles the DMA write port, tile clear/status,
// load request/status and the row-stream handshake of weight_tile_buffer.
//   master : driven by the DMA / load controller / PE array side
//   slave  : the weight_tile_buffer itself
interface weight_tile_buffer_if #(
  parameter int DW    = 16,
  parameter int N     = 8,
  parameter int TILES = 2
);
  localparam int TW = $clog2(TILES);
  localparam int AW = $clog2(N*N);
  localparam int RW = AW/2;

  logic              wr_en;
  logic [TW-1:0]     wr_tile;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              wr_err;
  logic [TILES-1:0]  tile_clr;
  logic [TILES-1:0]  tile_valid;
  logic              load_req;
  logic [TW-1:0]     load_tile;
  logic              busy;
  logic              load_done;
  logic              load_err;
  logic              w_row_valid;
  logic              w_row_ready;
  logic [RW-1:0]     w_row_idx;
  logic [N*DW-1:0]   w_row_data;

  modport master (
    output wr_en, wr_tile, wr_addr, wr_data, tile_clr, load_req, load_tile, w_row_ready,
    input  wr_err, tile_valid, busy, load_done, load_err, w_row_valid, w_row_idx, w_row_data
  );

  modport slave (
    input  wr_en, wr_tile, wr_addr, wr_data, tile_clr, load_req, load_tile, w_row_ready,
    output wr_err, tile_valid, busy, load_done, load_err, w_row_valid, w_row_idx, w_row_data
  );
endinterface

// File: rtl/weight_tile_buffer.sv
// weight_tile_buffer: TILES-slot weight store for the NxN systolic array.
// DMA writes single words into any slot while a per-tile fill bitmap tracks
// which words are present; a full tile can be streamed out one row per cycle
// (row N-1 first, row 0 last) over a valid/ready handshake, so one slot can be
// refilled while another streams.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high; clears FSM, memory, bitmaps, outputs
//   bus    : weight_tile_buffer_if.slave (write port, tile_clr/tile_valid,
//            load_req/busy/load_done/load_err, row stream)
module weight_tile_buffer #(
  parameter int DW    = 16,
  parameter int N     = 8,
  parameter int TILES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  weight_tile_buffer_if.slave   bus
);
  localparam int TW    = $clog2(TILES);
  localparam int AW    = $clog2(N*N);
  localparam int RW    = AW/2;
  localparam int WORDS = N*N;

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_STREAM = 1'b1;

  logic [TILES-1:0][WORDS-1:0][DW-1:0] mem_q;
  logic [TILES-1:0][WORDS-1:0]         bmp_q, bmp_d;
  logic [TILES-1:0]                    tv_q, tv_d;
  logic [0:0]                          state_q, state_d;
  logic [RW-1:0]                       row_q, row_d;
  logic [TW-1:0]                       tile_q, tile_d;
  logic                                wr_err_q, done_q, done_d, lerr_q, lerr_d;
  logic                                wr_drop, wr_ok;
  logic [N*DW-1:0]                     row_data;

  // The slot being streamed is frozen: writes to it are dropped so the rows
  // already committed to the array stay coherent.
  assign wr_drop = bus.wr_en && (state_q == S_STREAM) && (bus.wr_tile == tile_q);
  assign wr_ok   = bus.wr_en && !wr_drop;

  // Clear takes effect before a same-cycle write to the same tile.
  always_comb begin
    bmp_d = bmp_q;
    for (int t = 0; t < TILES; t++)
      if (bus.tile_clr[t]) bmp_d[t] = '0;
    if (wr_ok) bmp_d[bus.wr_tile][bus.wr_addr] = 1'b1;
  end

  always_comb begin
    for (int t = 0; t < TILES; t++) tv_d[t] = &bmp_q[t];
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    tile_d  = tile_q;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.load_req) begin
          if (tv_q[bus.load_tile]) begin
            state_d = S_STREAM;
            row_d   = {RW{1'b1}};   // N-1, N is a power of two
            tile_d  = bus.load_tile;
          end else begin
            lerr_d = 1'b1;
          end
        end
      end
      default: begin
        if (bus.load_req) lerr_d = 1'b1;
        if (bus.w_row_ready) begin
          if (row_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            row_d = row_q - RW'(1);
          end
        end
      end
    endcase
  end

  // Row word c lives at tile address {row, c}.
  always_comb begin
    row_data = '0;
    if (state_q == S_STREAM)
      for (int c = 0; c < N; c++)
        row_data[c*DW +: DW] = mem_q[tile_q][{row_q, c[RW-1:0]}];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      bmp_q    <= '0;
      tv_q     <= '0;
      state_q  <= S_IDLE;
      row_q    <= '0;
      tile_q   <= '0;
      wr_err_q <= 1'b0;
      done_q   <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      if (wr_ok) mem_q[bus.wr_tile][bus.wr_addr] <= bus.wr_data;
      bmp_q    <= bmp_d;
      tv_q     <= tv_d;
      state_q  <= state_d;
      row_q    <= row_d;
      tile_q   <= tile_d;
      wr_err_q <= wr_drop;
      done_q   <= done_d;
      lerr_q   <= lerr_d;
    end
  end

  assign bus.wr_err      = wr_err_q;
  assign bus.tile_valid  = tv_q;
  assign bus.busy        = (state_q == S_STREAM);
  assign bus.load_done   = done_q;
  assign bus.load_err    = lerr_q;
  assign bus.w_row_valid = (state_q == S_STREAM);
  assign bus.w_row_idx   = row_q;
  assign bus.w_row_data  = row_data;
endmodule

// File: tb/tb_weight_tile_buffer.sv
module tb_weight_tile_buffer;
  localparam int DW = 16, N = 8, TILES = 2;
  localparam int TW = $clog2(TILES), AW = $clog2(N*N), RW = AW/2;
  localparam int WW = N*DW, WORDS = N*N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  weight_tile_buffer_if #(.DW(DW), .N(N), .TILES(TILES)) bus();
  weight_tile_buffer #(.DW(DW), .N(N), .TILES(TILES)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [RW-1:0] idx;
    logic [WW-1:0] data;
  } row_t;
  row_t sbq[$];

  // Reference model: word store, fill flags, registered tile_valid, and a
  // simple "tile in flight with k rows left" view of streaming.
  logic [DW-1:0]    m_mem  [TILES][WORDS];
  bit               m_fill [TILES][WORDS];
  logic [TILES-1:0] m_tv;
  bit               m_act;
  int               m_tile, m_left;

  task automatic chk(string nm, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int t = 0; t < TILES; t++)
      for (int a = 0; a < WORDS; a++) begin
        m_mem[t][a]  = '0;
        m_fill[t][a] = 0;
      end
    m_tv = '0; m_act = 0; m_tile = 0; m_left = 0;
    sbq.delete();
  endtask

  task automatic idle_in();
    bus.wr_en = 0; bus.wr_tile = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.tile_clr = '0; bus.load_req = 0; bus.load_tile = '0; bus.w_row_ready = 0;
  endtask

  // Predict the effect of the current inputs at the next edge, advance one
  // cycle, then compare the status outputs.
  task automatic tick();
    bit werr = 0, lerr = 0, done = 0, drop;
    logic [TILES-1:0] tvn;
    row_t e;
    for (int t = 0; t < TILES; t++) begin
      tvn[t] = 1'b1;
      for (int a = 0; a < WORDS; a++) if (!m_fill[t][a]) tvn[t] = 1'b0;
    end
    drop = bus.wr_en && m_act && (int'(bus.wr_tile) == m_tile);
    werr = drop;
    if (!m_act) begin
      if (bus.load_req) begin
        if (m_tv[bus.load_tile]) begin
          m_act = 1; m_tile = int'(bus.load_tile); m_left = N;
          for (int r = N-1; r >= 0; r--) begin
            e.idx = RW'(r);
            for (int c = 0; c < N; c++) e.data[c*DW +: DW] = m_mem[m_tile][r*N+c];
            sbq.push_back(e);
          end
        end else lerr = 1;
      end
    end else begin
      if (bus.load_req) lerr = 1;
      if (bus.w_row_ready) begin
        m_left--;
        if (m_left == 0) begin m_act = 0; done = 1; end
      end
    end
    for (int t = 0; t < TILES; t++)
      if (bus.tile_clr[t]) for (int a = 0; a < WORDS; a++) m_fill[t][a] = 0;
    if (bus.wr_en && !drop) begin
      m_mem[bus.wr_tile][bus.wr_addr]  = bus.wr_data;
      m_fill[bus.wr_tile][bus.wr_addr] = 1;
    end
    m_tv = tvn;
    @(posedge clk); #1;
    chk("wr_err",      WW'(bus.wr_err),      WW'(werr));
    chk("load_err",    WW'(bus.load_err),    WW'(lerr));
    chk("load_done",   WW'(bus.load_done),   WW'(done));
    chk("busy",        WW'(bus.busy),        WW'(m_act));
    chk("w_row_valid", WW'(bus.w_row_valid), WW'(m_act));
    chk("tile_valid",  WW'(bus.tile_valid),  WW'(m_tv));
  endtask

  task automatic wr(int t, int a, logic [DW-1:0] d);
    bus.wr_en = 1; bus.wr_tile = TW'(t); bus.wr_addr = AW'(a); bus.wr_data = d;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic req(int t);
    bus.load_req = 1; bus.load_tile = TW'(t);
    tick();
    bus.load_req = 0;
  endtask

  task automatic drain(int maxc);
    int n = 0;
    bus.w_row_ready = 1;
    while (m_act && n < maxc) begin tick(); n++; end
    chk("drain_timeout_busy", WW'(bus.busy), WW'(0));
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_busy"},       WW'(bus.busy),        WW'(0));
    chk({tag, "_valid"},      WW'(bus.w_row_valid), WW'(0));
    chk({tag, "_tile_valid"}, WW'(bus.tile_valid),  WW'(0));
    chk({tag, "_row_idx"},    WW'(bus.w_row_idx),   WW'(0));
    chk({tag, "_row_data"},   bus.w_row_data,       WW'(0));
    chk({tag, "_errs_done"},  WW'({bus.wr_err, bus.load_err, bus.load_done}), WW'(0));
  endtask

  // Monitor: pops the expected row on every transfer and checks that a
  // stalled row is held unchanged with valid kept high.
  logic [RW-1:0] p_idx;
  logic [WW-1:0] p_data;
  bit            have_p = 0;
  row_t          me;
  always @(negedge clk) begin
    if (reset) have_p = 0;
    else begin
      if (have_p) begin
        chk("stall_valid_held", WW'(bus.w_row_valid), WW'(1));
        if (bus.w_row_valid) begin
          chk("stall_idx_held",  WW'(bus.w_row_idx), WW'(p_idx));
          chk("stall_data_held", bus.w_row_data, p_data);
        end
      end
      if (bus.w_row_valid && bus.w_row_ready) begin
        if (sbq.size() == 0) chk("unexpected_row", WW'(1), WW'(0));
        else begin
          me = sbq.pop_front();
          chk("row_idx",  WW'(bus.w_row_idx), WW'(me.idx));
          chk("row_data", bus.w_row_data, me.data);
        end
      end
      have_p = bus.w_row_valid && !bus.w_row_ready;
      p_idx  = bus.w_row_idx;
      p_data = bus.w_row_data;
    end
  end

  task automatic mid_reset();
    #2 reset = 1;
    #1 check_reset_outputs("async_reset");
    m_reset();
    @(negedge clk) reset = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_in();
    m_reset();
    #12 check_reset_outputs("reset");
    @(negedge clk) reset = 0;
    @(posedge clk); #1;

    // Tile 0 filled with word = address, then streamed with ready high.
    for (int a = 0; a < WORDS; a++) wr(0, a, DW'(a));
    tick(); tick();
    chk("tile0_valid_after_fill", WW'(bus.tile_valid), WW'(2'b01));
    req(0);
    chk("first_row_idx", WW'(bus.w_row_idx), WW'(N-1));
    drain(20);

    // Tile 1 one word short: rejected, then accepted once complete.
    for (int a = 0; a < WORDS; a++) if (a != 37) wr(1, a, DW'($urandom));
    tick(); tick();
    req(1);
    chk("short_tile_busy", WW'(bus.busy), WW'(0));
    wr(1, 37, 16'hBEEF);
    tick(); tick();
    req(1);
    drain(20);

    // Stalling stream: ready pattern 1,0,0,1.
    req(0);
    for (int i = 0; i < 40 && m_act; i++) begin
      bus.w_row_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    drain(20);

    // Refill tile 1 while tile 0 streams stalled; writes to tile 0 drop.
    bus.tile_clr = 2'b10; tick(); bus.tile_clr = '0;
    bus.w_row_ready = 0;
    req(0);
    for (int a = 0; a < WORDS; a++) begin
      wr(1, a, DW'(a) ^ 16'hA5A5);
      if (a == 10 || a == 50) wr(0, 3, 16'hFFFF);
    end
    drain(20);
    tick(); tick();
    req(1); drain(20);
    req(0); drain(20);

    // Clear and write the same tile in one cycle.
    bus.tile_clr = 2'b01;
    wr(0, 9, 16'h1234);
    bus.tile_clr = '0;
    tick(); tick();
    chk("clr_write_tile0_invalid", WW'(bus.tile_valid[0]), WW'(0));

    // Reset mid-stream after four rows.
    for (int a = 0; a < WORDS; a++) wr(0, a, DW'($urandom));
    tick(); tick();
    req(0);
    bus.w_row_ready = 1;
    for (int i = 0; i < 4; i++) tick();
    bus.w_row_ready = 0;
    mid_reset();
    req(0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bus.wr_en       = $urandom_range(0, 3) != 0;
      bus.wr_tile     = TW'($urandom_range(0, TILES-1));
      bus.wr_addr     = AW'($urandom_range(0, WORDS-1));
      bus.wr_data     = DW'($urandom);
      bus.tile_clr    = ($urandom_range(0, 399) == 0) ? TILES'($urandom) : '0;
      bus.load_req    = $urandom_range(0, 7) == 0;
      bus.load_tile   = TW'($urandom_range(0, TILES-1));
      bus.w_row_ready = $urandom_range(0, 3) != 0;
      if (bus.load_req && bus.wr_en && bus.wr_tile == bus.load_tile) bus.wr_en = 0;
      tick();
    end
    idle_in();
    drain(40);
    tick();
    chk("scoreboard_empty", WW'(sbq.size()), WW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/weight_tile_buffer.md
# weight_tile_buffer

Parametrised, multi-tile weight store for the NxN systolic PE array. It accepts DMA word writes into any of TILES independent tile slots and tracks per-word fill status. On request, it streams a complete tile into the array one row per cycle over a valid/ready handshake. It replaces the single-tile, all-at-once weight load with a row-shift load, so the DMA can refill one tile while another is being streamed.

## Interface
Parameters:
- DW, 16: weight word width.
- N, 8: PE array dimension; N >= 2, power of two; a tile is N*N words.
- TILES, 2: number of tile slots; TILES >= 2, power of two.
- Derived: TW = clog2(TILES); AW = clog2(N*N).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  DMA write strobe.
- wr_tile  in  TW  destination tile slot.
- wr_addr  in  AW  word index in tile; row = wr_addr / N, column = wr_addr % N.
- wr_data  in  DW  weight word.
- wr_err  out  1  one-cycle pulse when a write is dropped.
- tile_clr  in  TILES  per-tile clear of the fill bitmap.
- tile_valid  out  TILES  bit t = all N*N words of tile t written since its last clear.
- load_req  in  1  request to stream a tile.
- load_tile  in  TW  tile to stream.
- busy  out  1  streaming in progress.
- load_done  out  1  one-cycle pulse after the last row is accepted.
- load_err  out  1  one-cycle pulse when a load_req is rejected.
- w_row_valid  out  1  row data valid.
- w_row_ready  in  1  array accepts a row.
- w_row_idx  out  AW/2  index of the row currently presented.
- w_row_data  out  N*DW  row data; bits [(c+1)*DW-1 : c*DW] = word at row w_row_idx, column c.

## Operation
- Storage: TILES*N*N words of DW bits, plus an N*N-bit fill bitmap per tile. tile_valid[t] is the AND-reduction of bitmap t, registered.
- Write path:
  - wr_en stores wr_data at (wr_tile, wr_addr) and sets the matching bitmap bit.
  - Rewriting a word is legal.
  - A write to the tile currently being streamed is dropped and pulses wr_err the next cycle; memory and bitmap are unchanged.
- Clear: tile_clr[t] zeroes bitmap t; memory contents are kept. If a clear and a write hit the same tile in the same cycle, the clear applies first, then the write sets its bit. Clearing the tile being streamed does not stop the stream.
- FSM has two states, IDLE and STREAM.
  - IDLE: load_req is accepted only if tile_valid[load_tile] = 1. On acceptance, go to STREAM with row counter = N-1 and busy = 1. If the tile is not valid, load_err pulses and the FSM stays in IDLE.
  - STREAM: present row r with w_row_valid = 1. A transfer occurs when w_row_valid && w_row_ready. Rows go out in order N-1 down to 0, so row 0 is the last one shifted in and ends at the top of the array. When row 0 transfers, return to IDLE, drop busy, and pulse load_done.
  - A load_req arriving while in STREAM is ignored and pulses load_err.
- Reset (including mid-stream): FSM to IDLE; all bitmaps and memory words cleared to 0; all outputs 0.

## Timing
- Reset values: wr_err 0, tile_valid 0, busy 0, load_done 0, load_err 0, w_row_valid 0, w_row_idx 0, w_row_data 0.
- A write at edge k is visible to a stream starting at edge k+1 or later. tile_valid reflects the write after edge k+1, i.e. one cycle of bitmap-reduce latency.
- load_req accepted at edge k: busy and w_row_valid are high after edge k+1, with w_row_idx = N-1.
- With w_row_ready held high, one row transfers per cycle. After acceptance at edge k, row 0 transfers at edge k+N, and load_done is high for the cycle after edge k+N, coincident with busy = 0.
- While w_row_ready is low, w_row_idx and w_row_data are held stable and w_row_valid stays high. The block never drops w_row_valid mid-tile.
- A new load_req is accepted in the same cycle load_done is high, giving back-to-back tiles with a one-cycle bubble.
- wr_err and load_err are registered and high for exactly one cycle per offending request.

## Test plan
- Fill tile 0 with word value = address (0..63), N=8 -> tile_valid = 2'b01 two cycles after the last write. load_req with tile 0 and ready high -> 8 rows over 8 cycles, row index 7 first with data {63..56}, row 0 last with data {7..0}, then a single load_done pulse.
- load_req for tile 1 while it holds 63/64 words -> load_err pulse, busy stays 0. Write the missing word, then re-request -> stream accepted.
- Stream tile 0 while w_row_ready toggles 1,0,0,1 -> each row is held stable during the stall, with no duplicated or skipped row index.
- During a tile 0 stream: write to tile 0 -> wr_err pulse and stored data unchanged. Write tile 1 in the same cycle instead -> accepted, and tile_valid[1] updates.
- tile_clr = 2'b01 plus a write to tile 0 in the same cycle -> bitmap holds only that word, so tile_valid[0] = 0.
- Assert reset at row 4 of a stream -> busy, w_row_valid and tile_valid go to 0 immediately. A subsequent load_req gives load_err.
